// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with shift counter and word-done pulse
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [2:0]                 i_mode,
  input  logic                       i_sin,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_out,
  output logic                       o_sout,
  output logic [$clog2(WIDTH)-1:0]   o_cnt,
  output logic                       o_word_done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  // Counter wraps at WIDTH-1 so non-power-of-two widths count 0..WIDTH-1.
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  // Next-state decode: data path per mode, then shared counter/pulse logic for shift ops.
  always_comb begin
    out_d    = out_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (i_en) begin
      case (i_mode)
        MODE_SHL: begin
          out_d    = {out_q[WIDTH-2:0], i_sin};
          sout_d   = out_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          out_d    = {i_sin, out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          out_d    = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          sout_d   = out_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          out_d    = {out_q[0], out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        MODE_ASR: begin
          out_d    = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          out_d = i_din;
          cnt_d = '0;
        end
        MODE_CLR: begin
          out_d  = '0;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        MODE_HOLD: begin
          out_d = out_q;
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
    if (is_shift) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with asynchronous reset; every output comes straight from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q  <= RESET_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_out       = out_q;
  assign o_sout      = sout_q;
  assign o_cnt       = cnt_q;
  assign o_word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg at WIDTH=8 and WIDTH=6
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] din;

  logic [7:0] out8;
  logic       sout8;
  logic [2:0] cnt8;
  logic       done8;
  logic [5:0] out6;
  logic       sout6;
  logic [2:0] cnt6;
  logic       done6;

  int total = 0;
  int bad   = 0;

  // Reference state, index 0 = WIDTH 8, index 1 = WIDTH 6
  longint unsigned m_out [2];
  longint unsigned m_sout[2];
  longint unsigned m_cnt [2];
  longint unsigned m_done[2];
  int              m_w   [2] = '{8, 6};
  longint unsigned m_rv  [2] = '{0, 64'h2A};

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sin(sin), .i_din(din),
    .o_out(out8), .o_sout(sout8), .o_cnt(cnt8), .o_word_done(done8)
  );

  univ_shift_reg #(.WIDTH(6), .RESET_VAL(6'h2A)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sin(sin), .i_din(din[5:0]),
    .o_out(out6), .o_sout(sout6), .o_cnt(cnt6), .o_word_done(done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = m_rv[k];
      m_sout[k] = 0;
      m_cnt[k]  = 0;
      m_done[k] = 0;
    end
  endtask

  // Arithmetic view of the register: shifts as multiply/divide by two modulo 2**W
  task automatic model_update(input logic e, input logic [2:0] md, input logic s, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      longint unsigned full = longint'(1) << m_w[k];
      longint unsigned half = full / 2;
      longint unsigned v    = m_out[k];
      bit shifted = 0;
      m_done[k] = 0;
      if (e) begin
        case (md)
          3'd1: begin m_sout[k] = v / half; m_out[k] = (v * 2 + s) % full; shifted = 1; end
          3'd2: begin m_sout[k] = v % 2; m_out[k] = v / 2 + s * half; shifted = 1; end
          3'd3: begin m_sout[k] = v / half; m_out[k] = (v * 2) % full + v / half; shifted = 1; end
          3'd4: begin m_sout[k] = v % 2; m_out[k] = v / 2 + (v % 2) * half; shifted = 1; end
          3'd6: begin m_sout[k] = v % 2; m_out[k] = v / 2 + (v / half) * half; shifted = 1; end
          3'd5: begin m_out[k] = d % full; m_cnt[k] = 0; end
          3'd7: begin m_out[k] = 0; m_cnt[k] = 0; m_sout[k] = 0; end
          default: ;
        endcase
      end
      if (shifted) begin
        m_cnt[k] = (m_cnt[k] + 1) % m_w[k];
        if (m_cnt[k] == 0) m_done[k] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " out8"},  out8,  m_out[0]);
    check({tag, " sout8"}, sout8, m_sout[0]);
    check({tag, " cnt8"},  cnt8,  m_cnt[0]);
    check({tag, " done8"}, done8, m_done[0]);
    check({tag, " out6"},  out6,  m_out[1]);
    check({tag, " sout6"}, sout6, m_sout[1]);
    check({tag, " cnt6"},  cnt6,  m_cnt[1]);
    check({tag, " done6"}, done6, m_done[1]);
  endtask

  // Called at a negative edge: drive, take one rising edge, check at the next negative edge
  task automatic step(input string tag, input logic e, input logic [2:0] md, input logic s,
                      input logic [7:0] d);
    en = e; mode = md; sin = s; din = d;
    @(posedge clk);
    model_update(e, md, s, d);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] exp_out [8];
    logic [7:0] exp_sout;
    logic [7:0] ser;
    rst = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0; din = 8'h00;

    // Asynchronous reset, observed before any clock edge
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=6 reset value rotated all the way round, pulse on sixth ROL only
    for (int i = 0; i < 6; i++) begin
      step("rol6", 1'b1, 3'd3, 1'b0, 8'h00);
      check("rol6_done", done6, (i == 5) ? 1 : 0);
    end
    check("rol6_final", out6, 64'h2A);

    // LOAD A5 then 8 SHL with zero serial input
    exp_out  = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    exp_sout = 8'b10100101;
    step("load_a5", 1'b1, 3'd5, 1'b0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      step("shl_a5", 1'b1, 3'd1, 1'b0, 8'h00);
      check("shl_a5_out", out8, exp_out[i]);
      check("shl_a5_sout", sout8, exp_sout[7-i]);
      check("shl_a5_done", done8, (i == 7) ? 1 : 0);
    end
    step("hold_after", 1'b1, 3'd0, 1'b0, 8'h00);
    check("done_clears", done8, 0);

    // ROR of 81 and ASR of 80
    step("load_81", 1'b1, 3'd5, 1'b0, 8'h81);
    step("ror1", 1'b1, 3'd4, 1'b0, 8'h00); check("ror1_out", out8, 8'hC0); check("ror1_sout", sout8, 1);
    step("ror2", 1'b1, 3'd4, 1'b1, 8'h00); check("ror2_out", out8, 8'h60); check("ror2_sout", sout8, 0);
    step("ror3", 1'b1, 3'd4, 1'b0, 8'h00); check("ror3_out", out8, 8'h30); check("ror3_sout", sout8, 0);
    step("load_80", 1'b1, 3'd5, 1'b0, 8'h80);
    step("asr", 1'b1, 3'd6, 1'b0, 8'h00); check("asr_out", out8, 8'hC0);

    // Serial deserialise 3C from CLR
    ser = 8'h3C;
    step("clr", 1'b1, 3'd7, 1'b1, 8'hFF);
    for (int i = 7; i >= 0; i--) step("deser", 1'b1, 3'd1, ser[i], 8'h00);
    check("deser_out", out8, 8'h3C);
    check("deser_cnt", cnt8, 0);
    check("deser_done", done8, 1);

    // Disabled cycles hold everything
    step("load_0f", 1'b1, 3'd5, 1'b0, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      step("en_low", 1'b0, 3'd1, 1'b1, 8'h00);
      check("en_low_out", out8, 8'h0F);
      check("en_low_cnt", cnt8, 0);
      check("en_low_done", done8, 0);
    end

    // Reset between edges after 3 SHL discards the partial count
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 3'd1, 1'b1, 8'h00);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_shl", 1'b1, 3'd1, 1'b0, 8'h00);
    check("post_rst_cnt", cnt8, 1);

    // Random operations against the model
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
